instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the control decode path: takes instruction fields over a valid/ready stream and encodes them into 32-bit RV32I words (R/I/S/B/U/J).
- Writes each word sequentially into instruction memory through a word-write port.
- Used by the bench and the boot path to preload programs into instruction memory before the core is released.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH, 1024, max words per load session.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a load session; only sampled in IDLE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  in  7  opcode field.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field.
- imm  in  32  immediate, byte-offset form.
- last  in  1  marks the final bundle of the session.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  encoded word.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle pulse at session end.
- count  out  32  words written this session.
- err  out  1  sticky error flag; cleared at the next accepted start.

Behaviour:
- Reset (async, rst=0):
  - FSM goes to IDLE.
  - in_ready, mem_we, busy, done and err are 0.
  - mem_addr = BASE_ADDR; mem_wdata = 0; count = 0.
  - A write in progress is abandoned and mem_we drops immediately.
- States:
  - IDLE: start=1 -> LOAD; addr=BASE_ADDR, count=0, err=0.
  - LOAD: in_ready=1. On in_valid & in_ready, register the encoded word and the last flag -> WRITE.
  - WRITE: mem_we=1 for exactly one cycle with the registered addr/word. Then addr+=4 and count+=1.
    - If last was latched -> DONE.
    - Else if count+1 == DEPTH -> set err -> DONE.
    - Else -> LOAD.
  - DONE: done=1 for one cycle -> IDLE.
- Throughput: one word per 2 cycles. Latency from the accept edge to mem_we is 1 cycle.
- start while busy is ignored. in_valid outside LOAD is ignored; no bundle is accepted.
- Encoding (opcode in [6:0] for every format):
  - R: funct7 | rs2 | rs1 | funct3 | rd.
  - I: imm[11:0] | rs1 | funct3 | rd.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U: imm[31:12] | rd.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
  - Unused imm bits are dropped. funct7 is ignored except in R.
- Illegal fmt (6/7): word = 32'h0000_0013 (NOP), err set, write still performed.
- DEPTH boundary: a session never writes more than DEPTH words.
- mem_addr wraps modulo 2^32; no special handling.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- Defined: err is set (word still written, truncated) when any of these hold:
  - I/S imm is outside -2048..2047.
  - B imm is outside -4096..4094 or imm[0]=1.
  - J imm is outside ±1 MiB or imm[0]=1.
  - U imm[11:0] != 0.
- Undefined: no range checks; bits are truncated silently. err comes only from an illegal fmt or DEPTH overflow.

Test Plan:
- Reset then start. Send R add: opcode 0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0, last=1 -> mem_we one cycle, mem_addr 0x0, mem_wdata 0x002081B3; done pulses; count=1; err=0.
- Three-bundle session, last on the third:
  - lw: I, op 0x03, rd=5, rs1=2, f3=2, imm=8 -> 0x00812283 @0x0.
  - sw: S, op 0x23, rs2=5, rs1=2, f3=2, imm=12 -> 0x00512623 @0x4.
  - jal: J, op 0x6F, rd=1, imm=16 -> 0x010000EF @0x8.
  - Then count=3.
- B beq: op 0x63, rs1=0, rs2=0, f3=0, imm=8 -> 0x00000463. With in_valid held high continuously, writes occur every 2nd cycle.
- fmt=7 bundle -> mem_wdata 0x00000013, err=1. err stays 1 after done and clears on the next start.
- DEPTH=4, stream 6 bundles with no last:
  - Exactly 4 writes occur (addr 0x0 to 0xC), then err=1 and done.
  - in_ready stays low afterwards.
- Drive rst low in the cycle mem_we is high -> mem_we, busy and count drop to 0 asynchronously. A following start restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that streams encoded words into instruction memory, one word per two cycles.
// Optional: define ENC_RANGE_CHECK_EN to flag immediates that do not fit their format (the word is still written, truncated).
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  input  logic        i_last,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_count,
  output logic        o_err
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
  localparam logic [31:0] DEPTH_W = DEPTH;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_word, r_count;
  logic        r_last, r_err;
  logic [31:0] w_word;
  logic        w_enc_err, w_accept, w_full;

  assign w_accept = (r_state == S_LOAD) && i_in_valid;
  assign w_full   = (r_count + 32'd1) == DEPTH_W;

  always_comb begin
    w_word    = NOP;
    w_enc_err = 1'b0;
    case (i_fmt)
      3'd0: w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      3'd1: w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      3'd2: w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      3'd3: w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
      3'd4: w_word = {i_imm[31:12], i_rd, i_opcode};
      3'd5: w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: w_enc_err = 1'b1;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (i_fmt)
      3'd1, 3'd2: if ($signed(i_imm) < -32'sd2048 || $signed(i_imm) > 32'sd2047) w_enc_err = 1'b1;
      3'd3: if ($signed(i_imm) < -32'sd4096 || $signed(i_imm) > 32'sd4094 || i_imm[0]) w_enc_err = 1'b1;
      3'd5: if ($signed(i_imm) < -32'sd1048576 || $signed(i_imm) > 32'sd1048574 || i_imm[0]) w_enc_err = 1'b1;
      3'd4: if (i_imm[11:0] != 12'd0) w_enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  if (i_in_valid) w_next = S_WRITE;
      S_WRITE: w_next = (r_last || w_full) ? S_DONE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    o_in_ready = (r_state == S_LOAD);
    o_mem_we   = (r_state == S_WRITE);
    o_busy     = (r_state != S_IDLE);
    o_done     = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= BASE_ADDR;
      r_word  <= 32'd0;
      r_count <= 32'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_addr  <= BASE_ADDR;
          r_count <= 32'd0;
          r_err   <= 1'b0;
        end
        S_LOAD: if (w_accept) begin
          r_word <= w_word;
          r_last <= i_last;
          if (w_enc_err) r_err <= 1'b1;
        end
        S_WRITE: begin
          r_addr  <= r_addr + 32'd4;
          r_count <= r_count + 32'd1;
          if (!r_last && w_full) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_word;
  assign o_count     = r_count;
  assign o_err       = r_err;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes are queued by the driver and checked by a negedge monitor.
module tb_instr_encoder_loader;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_in_valid = 1'b0, i_last = 1'b0;
  logic [2:0]  i_fmt = '0, i_funct3 = '0;
  logic [6:0]  i_opcode = '0, i_funct7 = '0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [31:0] i_imm = '0;
  logic        o_in_ready, o_mem_we, o_busy, o_done, o_err;
  logic [31:0] o_mem_addr, o_mem_wdata, o_count;

  instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_fmt(i_fmt), .i_opcode(i_opcode), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_imm(i_imm), .i_last(i_last), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_done(o_done), .o_count(o_count),
    .o_err(o_err));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         q[$];
  int          total = 0, bad = 0;
  int          cyc = 0, prev_wr = 0;
  bit          gap_on = 0, have_prev = 0;
  logic [31:0] exp_addr;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  initial forever begin
    wr_t e;
    @(negedge i_clk);
    if (o_mem_we) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", o_mem_addr, o_mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", o_mem_addr, e.addr);
        chk("wr_data", o_mem_wdata, e.data);
      end
      if (gap_on && have_prev) chk("wr_gap", cyc - prev_wr, 2);
      prev_wr = cyc; have_prev = 1;
    end
  end

  task automatic start_session();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    exp_addr = 32'h0;
  endtask

  // Drive one bundle, keep in_valid high, return 1 ns after its accept edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic lst,
                      input logic [31:0] exp_word, input bit expect_wr);
    int n;
    wr_t e;
    i_fmt = fmt; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm; i_last = lst; i_in_valid = 1'b1;
    if (expect_wr) begin
      e.addr = exp_addr; e.data = exp_word; q.push_back(e);
      exp_addr += 4;
    end
    n = 0;
    while (n < 20) begin
      @(negedge i_clk);
      if (o_in_ready) break;
      n++;
    end
    if (n == 20) chk("ready_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic wait_done(input logic [31:0] exp_count, input logic exp_err);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge i_clk);
      if (o_done) break;
      n++;
    end
    if (n == 20) chk("done_timeout", 0, 1);
    else begin
      chk("done_count", o_count, exp_count);
      chk("done_err", {31'd0, o_err}, {31'd0, exp_err});
    end
    @(negedge i_clk);
    chk("done_pulse_one_cycle", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, o_in_ready}, 0);
    chk("rst_we",    {31'd0, o_mem_we}, 0);
    chk("rst_busy",  {31'd0, o_busy}, 0);
    chk("rst_addr",  o_mem_addr, 32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_count", o_count, 32'h0);
    i_rst_n = 1'b1;

    // single R add
    start_session();
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b1, 32'h002081B3, 1);
    i_in_valid = 1'b0;
    wait_done(1, 1'b0);

    // lw / sw / jal
    start_session();
    send(3'd1, 7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'd8,  1'b0, 32'h00812283, 1);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'd12, 1'b0, 32'h00512623, 1);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16, 1'b1, 32'h010000EF, 1);
    i_in_valid = 1'b0;
    wait_done(3, 1'b0);

    // continuous valid: beq +8, beq -4, addi -1; writes every other cycle
    start_session();
    gap_on = 1; have_prev = 0;
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,         1'b0, 32'h00000463, 1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'hFE000EE3, 1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093, 1);
    i_in_valid = 1'b0;
    wait_done(3, 1'b0);
    gap_on = 0;

    // lui, sub with funct7, then illegal fmt
    start_session();
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 1'b0, 32'h123450B7, 1);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         1'b0, 32'h402081B3, 1);
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         1'b1, 32'h00000013, 1);
    i_in_valid = 1'b0;
    wait_done(3, 1'b1);
    repeat (3) @(negedge i_clk);
    chk("err_sticky", {31'd0, o_err}, 1);
    start_session();
    chk("err_cleared", {31'd0, o_err}, 0);

    // DEPTH=4 overflow: six bundles offered, four written
    for (int k = 0; k < 4; k++)
      send(3'd1, 7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(k), 1'b0,
           {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13}, 1);
    wait_done(4, 1'b1);
    begin
      int seen = 0;
      repeat (6) begin @(negedge i_clk); if (o_in_ready || o_busy) seen++; end
      chk("ready_low_after_depth", seen, 0);
    end
    i_in_valid = 1'b0;

    // async reset during a write
    start_session();
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b1, 32'h0, 0);
    i_in_valid = 1'b0;
    chk("we_before_rst", {31'd0, o_mem_we}, 1);
    i_rst_n = 1'b0; #1;
    chk("rst_async_we",    {31'd0, o_mem_we}, 0);
    chk("rst_async_busy",  {31'd0, o_busy}, 0);
    chk("rst_async_count", o_count, 0);
    #5 i_rst_n = 1'b1;
    start_session();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b1, 32'h00500093, 1);
    i_in_valid = 1'b0;
    wait_done(1, 1'b0);

    repeat (2) @(negedge i_clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
